axi4_sram_slave: RTL

AXI4 responder backed by on-chip word memory; the slave end of the bus the core's 2x1 interconnect drives. It serves single-outstanding INCR/FIXED/WRAP bursts and is the memory model behind the core's `m00` port in simulation and FPGA bring-up. Read and write channels run independent state machines over a dual-ported array. Errors are returned in-band via `r_resp`/`b_resp`.

---
 rtl/axi4_pkg.sv | 30 +++
 rtl/axi4_burst_addr_gen.sv | 26 ++
 rtl/axi4_sram_slave.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 constants, burst descriptor and response helpers
package axi4_pkg;
   localparam int PROC_PALEN = 32;
   localparam int AXI_ID_W = 4;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;
   typedef struct packed {
      logic [AXI_ID_W-1:0] id;
      logic [PROC_PALEN-1:0] addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
   } axi4_burst_t;
   // Encodings happen to order numerically: DECERR > SLVERR > OKAY
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return a > b ? a : b;
   endfunction
   function automatic logic [1:0] beat_resp(input logic in_range, input logic ovf, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
      return (!in_range || ovf) ? RESP_DECERR :
             (size > 3'd2 || (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))) ? RESP_SLVERR :
             RESP_OKAY;
   endfunction
endpackage

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: next beat address for FIXED/INCR/WRAP plus window check
module axi4_burst_addr_gen import axi4_pkg::*; #(
   parameter int ADDR_WIDTH = PROC_PALEN,
   parameter int DEPTH = 16384,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            len,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  carry,
   output logic                  in_range
);
   logic [ADDR_WIDTH-1:0] aligned, inc, mask;
   logic c;
   always_comb begin
      aligned = {addr[ADDR_WIDTH-1:2], 2'b00};
      {c, inc} = {1'b0, aligned} + (ADDR_WIDTH+1)'(4);
      mask = ADDR_WIDTH'({len, 2'b11});
      next_addr = burst == BURST_FIXED ? addr :
                  burst == BURST_INCR ? inc :
                  burst == BURST_WRAP ? (aligned & ~mask) | (inc & mask) : addr;
      carry = burst == BURST_INCR && c;
      in_range = addr >= BASE_ADDR && {1'b0, addr - BASE_ADDR} < (ADDR_WIDTH+1)'(DEPTH * 4);
   end
endmodule

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: single-outstanding AXI4 responder over a dual-ported word memory
module axi4_sram_slave import axi4_pkg::*; #(
   parameter int ADDR_WIDTH = PROC_PALEN,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH = AXI_ID_W,
   parameter int DEPTH = 16384,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                    clk,
   input  logic                    a_rst_n,
   input  logic [ID_WIDTH-1:0]     aw_id,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]              aw_len,
   input  logic [2:0]              aw_size,
   input  logic [1:0]              aw_burst,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_last,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [ID_WIDTH-1:0]     b_id,
   output logic [1:0]              b_resp,
   output logic                    b_user,
   output logic                    b_valid,
   input  logic                    b_ready,
   input  logic [ID_WIDTH-1:0]     ar_id,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]              ar_len,
   input  logic [2:0]              ar_size,
   input  logic [1:0]              ar_burst,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [ID_WIDTH-1:0]     r_id,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_last,
   output logic                    r_user,
   output logic                    r_valid,
   input  logic                    r_ready
);
   localparam int IDX_W = $clog2(DEPTH);
   wr_state_e w_state, w_nxt;
   rd_state_e r_state, r_nxt;
   axi4_burst_t aw_q, ar_q;
   logic [7:0] w_cnt, r_cnt;
   logic ready_en, w_ovf, r_ovf, aw_hs, w_hs, ar_hs, r_hs, w_carry, r_carry, w_in, r_in;
   logic [1:0] w_stat, w_beat, b_acc, r_stat;
   logic [ADDR_WIDTH-1:0] w_addr, w_next, r_addr, r_next, r_ld;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wgen (
      .addr(w_addr), .len(aw_q.len), .burst(aw_q.burst), .next_addr(w_next), .carry(w_carry), .in_range(w_in));
   axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rgen (
      .addr(r_addr), .len(ar_q.len), .burst(ar_q.burst), .next_addr(r_next), .carry(r_carry), .in_range(r_in));

   always_comb begin
      w_addr = ADDR_WIDTH'(aw_q.addr);
      r_addr = ADDR_WIDTH'(ar_q.addr);
      aw_hs = aw_valid && aw_ready;
      w_hs = w_valid && w_ready;
      ar_hs = ar_valid && ar_ready;
      r_hs = r_valid && r_ready;
      w_stat = beat_resp(w_in, w_ovf, aw_q.size, aw_q.burst, aw_q.len);
      w_beat = resp_max(w_stat, (w_last != (w_cnt == aw_q.len)) ? RESP_SLVERR : RESP_OKAY);
      r_stat = beat_resp(r_in, r_ovf, ar_q.size, ar_q.burst, ar_q.len);
      r_ld = r_state == R_IDLE ? ar_addr : r_next;
   end

   always_ff @(posedge clk) begin
      if (!a_rst_n) w_state <= W_IDLE;
      else w_state <= w_nxt;
   end

   always_comb begin
      w_nxt = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
              w_state == W_DATA ? (w_hs && w_cnt == aw_q.len ? W_RESP : W_DATA) :
              (b_ready ? W_IDLE : W_RESP);
   end

   // ready_en keeps the address channels closed until the first edge out of reset
   always_comb begin
      aw_ready = ready_en && w_state == W_IDLE;
      w_ready = w_state == W_DATA;
      b_valid = w_state == W_RESP;
      b_id = ID_WIDTH'(aw_q.id);
      b_resp = b_acc;
      b_user = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!a_rst_n) begin
         ready_en <= 1'b0;
         aw_q <= '0;
         w_cnt <= '0;
         w_ovf <= 1'b0;
         b_acc <= RESP_OKAY;
      end else begin
         ready_en <= 1'b1;
         if (aw_hs) begin
            aw_q <= '{id: AXI_ID_W'(aw_id), addr: PROC_PALEN'(aw_addr), len: aw_len, size: aw_size, burst: aw_burst};
            w_cnt <= '0;
            w_ovf <= 1'b0;
            b_acc <= RESP_OKAY;
         end else if (w_hs) begin
            aw_q.addr <= PROC_PALEN'(w_next);
            w_cnt <= w_cnt + 8'd1;
            w_ovf <= w_ovf | w_carry;
            b_acc <= resp_max(b_acc, w_beat);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!a_rst_n) r_state <= R_IDLE;
      else r_state <= r_nxt;
   end

   always_comb begin
      r_nxt = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs && r_last ? R_IDLE : R_DATA);
   end

   always_comb begin
      ar_ready = ready_en && r_state == R_IDLE;
      r_valid = r_state == R_DATA;
      r_last = r_valid && r_cnt == ar_q.len;
      r_resp = r_valid ? r_stat : RESP_OKAY;
      r_data = r_valid && r_stat == RESP_OKAY ? rd_q : '0;
      r_id = ID_WIDTH'(ar_q.id);
      r_user = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!a_rst_n) begin
         ar_q <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (ar_hs) begin
         ar_q <= '{id: AXI_ID_W'(ar_id), addr: PROC_PALEN'(ar_addr), len: ar_len, size: ar_size, burst: ar_burst};
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (r_hs) begin
         ar_q.addr <= PROC_PALEN'(r_next);
         r_cnt <= r_cnt + 8'd1;
         r_ovf <= r_ovf | r_carry;
      end
   end

   // Read port samples before the write lands, so a same-word collision returns old data
   always_ff @(posedge clk) begin
      if (a_rst_n && w_hs && w_stat == RESP_OKAY)
         for (int i = 0; i < DATA_WIDTH/8; i++)
            if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
      if (ar_hs || r_hs) rd_q <= mem[word_idx(r_ld)];
   end
endmodule
